// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB-Lite encodings and the pipeline slot type used by
//               the ahb_lite_master initiator.
// Revision    : 1.0  initial release
// ============================================================================
package ahb_pkg;

    // HTRANS encodings; only IDLE and NONSEQ are ever driven
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Command size encodings (HSIZE[1:0]); 2'b11 is illegal on the command side
    localparam logic [1:0] HSIZE_BYTE = 2'b00;
    localparam logic [1:0] HSIZE_HALF = 2'b01;
    localparam logic [1:0] HSIZE_WORD = 2'b10;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // HRESP: only bit 0 carries meaning for this initiator
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // One pipeline stage (address-phase slot or data-phase slot)
    typedef struct packed {
        logic        valid;
        logic        write;
        logic        bad;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } slot_t;

    // A command is "bad" when it can never go on the bus: illegal size or an
    // address not aligned to its size. Byte accesses are always aligned.
    function automatic logic is_bad(input logic [1:0] size, input logic [1:0] addr_lsb);
        case (size)
            HSIZE_BYTE: return 1'b0;
            HSIZE_HALF: return addr_lsb[0];
            HSIZE_WORD: return |addr_lsb;
            default:    return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_master
// Description : AHB-Lite initiator turning a valid/ready command stream into
//               single NONSEQ transfers. Two-slot pipeline (address phase A,
//               data phase D), in-order one-cycle response pulses, two-cycle
//               ERROR handling with replay of the cancelled address phase.
// Ports       : HCLK/HRESETn        clock, async active-low reset
//               cmd_*               command stream (valid/ready handshake)
//               rsp_*               response pulse, no backpressure
//               H*                  AHB-Lite master interface
// Revision    : 1.0  initial release
// ============================================================================
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011,
    parameter int         RSP_REG   = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    // command stream
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    // response stream
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    // AHB-Lite master
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP,
    input  logic [31:0] HRDATA
);

    // Only the registered response path exists; any other value is unsupported.
    if (RSP_REG != 1) begin : g_rsp_reg_unsupported
    end

    slot_t       a_q, a_d;
    slot_t       d_q, d_d;
    logic        err_hold_q, err_hold_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        w_resp_err;
    logic        w_err_first;
    logic        w_accept;
    logic        w_unused_slot;

    assign w_resp_err  = ((HRESP & HRESP_ERROR) != HRESP_OKAY);
    // First cycle of the two-cycle ERROR response
    assign w_err_first = w_resp_err & ~HREADY;

    assign cmd_ready = (~a_q.valid | HREADY) & ~err_hold_q & ~w_err_first;
    assign w_accept  = cmd_valid & cmd_ready;

    // Address/control come straight from slot A; its fields are left intact
    // when A empties, so HADDR/HWRITE/HSIZE hold their last value.
    assign HTRANS    = (a_q.valid & ~a_q.bad & ~err_hold_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = a_q.addr;
    assign HWRITE    = a_q.write;
    assign HSIZE     = {1'b0, a_q.size};
    assign HWDATA    = d_q.wdata;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    // Address and size are never needed once a transfer is in its data phase
    assign w_unused_slot = ^{d_q.size, d_q.addr};

    always_comb begin
        a_d         = a_q;
        d_d         = d_q;
        err_hold_d  = err_hold_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;

        if (!HREADY) begin
            // Wait state: both slots hold; remember an ERROR first cycle
            if (w_resp_err) begin
                err_hold_d = 1'b1;
            end
        end else begin
            if (d_q.valid) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = d_q.bad | w_resp_err | err_hold_q;
                rsp_rdata_d = (d_q.write | d_q.bad) ? 32'h0 : HRDATA;
            end

            if (err_hold_q) begin
                // Second ERROR cycle: retire D, keep A for replay
                d_d.valid  = 1'b0;
                err_hold_d = 1'b0;
            end else begin
                d_d = a_q;
                if (w_accept) begin
                    a_d.valid = 1'b1;
                    a_d.write = cmd_write;
                    a_d.bad   = is_bad(cmd_size, cmd_addr[1:0]);
                    a_d.size  = cmd_size;
                    a_d.addr  = cmd_addr;
                    a_d.wdata = cmd_wdata;
                end else begin
                    a_d.valid = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_q         <= '0;
            d_q         <= '0;
            err_hold_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            a_q         <= a_d;
            d_q         <= d_d;
            err_hold_q  <= err_hold_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_lite_master
// Description : Cycle-by-cycle vector bench for ahb_lite_master plus a
//               hand-written asynchronous reset sequence.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_lite_master;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] NS = 2'b10;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS, HRESP;
    logic        HWRITE, HMASTLOCK, HREADY;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    always #5 HCLK = ~HCLK;

    ahb_lite_master #(.HPROT_VAL(4'b0011), .RSP_REG(1)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    // One record per bus cycle: inputs driven for the cycle and the outputs
    // expected during that same cycle (before the closing edge).
    typedef struct {
        logic        cv, cw;
        logic [1:0]  cs;
        logic [31:0] ca, cd;
        logic        hr, he;
        logic [31:0] hrd;
        logic [1:0]  e_trans;
        logic        e_rdy, e_rv, e_re;
        logic [31:0] e_rd;
        logic        chk_a;
        logic [31:0] e_haddr;
        logic        chk_w;
        logic [31:0] e_hwdata;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic v(input logic cv, input logic cw, input logic [1:0] cs,
                     input logic [31:0] ca, input logic [31:0] cd,
                     input logic hr, input logic he, input logic [31:0] hrd,
                     input logic [1:0] et, input logic erdy, input logic erv,
                     input logic ere, input logic [31:0] erd,
                     input logic chk_a, input logic [31:0] eha,
                     input logic chk_w, input logic [31:0] ehw);
        vec_t r;
        r.cv = cv; r.cw = cw; r.cs = cs; r.ca = ca; r.cd = cd;
        r.hr = hr; r.he = he; r.hrd = hrd;
        r.e_trans = et; r.e_rdy = erdy; r.e_rv = erv; r.e_re = ere; r.e_rd = erd;
        r.chk_a = chk_a; r.e_haddr = eha; r.chk_w = chk_w; r.e_hwdata = ehw;
        vecs.push_back(r);
    endtask

    // Quiet cycle: no command, slave ready/OKAY
    task automatic vi(input logic [31:0] hrd, input logic [1:0] et, input logic erv,
                      input logic ere, input logic [31:0] erd,
                      input logic chk_a, input logic [31:0] eha,
                      input logic chk_w, input logic [31:0] ehw);
        v(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, hrd,
          et, 1'b1, erv, ere, erd, chk_a, eha, chk_w, ehw);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // ------------------------------------------------ vector table
        // T1: word write 0x4000_0000 / DEADBEEF, no wait states
        v(1,1,2,32'h40000000,32'hDEADBEEF, 1,0,0, ID,1,0,0,0, 0,0, 0,0);
        vi(0, NS,0,0,0, 1,32'h40000000, 0,0);
        vi(0, ID,0,0,0, 0,0, 1,32'hDEADBEEF);
        vi(0, ID,1,0,0, 0,0, 0,0);
        vi(0, ID,0,0,0, 0,0, 0,0);
        // T2: back-to-back reads 0x10, 0x14
        v(1,0,2,32'h10,0, 1,0,0, ID,1,0,0,0, 0,0, 0,0);
        v(1,0,2,32'h14,0, 1,0,0, NS,1,0,0,0, 1,32'h10, 0,0);
        vi(32'h11111111, NS,0,0,0, 1,32'h14, 0,0);
        vi(32'h22222222, ID,1,0,32'h11111111, 1,32'h14, 0,0);
        vi(0, ID,1,0,32'h22222222, 0,0, 0,0);
        vi(0, ID,0,0,0, 0,0, 0,0);
        // T3: write 0x100 with 3 wait states, read 0x104 behind it
        v(1,1,2,32'h100,32'hCAFEF00D, 1,0,0, ID,1,0,0,0, 0,0, 0,0);
        v(1,0,2,32'h104,0, 1,0,0, NS,1,0,0,0, 1,32'h100, 0,0);
        for (int i = 0; i < 3; i++)
            v(0,0,0,0,0, 0,0,0, NS,0,0,0,0, 1,32'h104, 1,32'hCAFEF00D);
        v(0,0,0,0,0, 1,0,0, NS,1,0,0,0, 1,32'h104, 1,32'hCAFEF00D);
        vi(32'h33333333, ID,1,0,0, 0,0, 0,0);
        vi(0, ID,1,0,32'h33333333, 0,0, 0,0);
        vi(0, ID,0,0,0, 0,0, 0,0);
        // T4: ERROR on first of two writes 0x20, 0x24; command offered
        // during both error cycles must not be taken
        v(1,1,2,32'h20,32'hA5A5A5A5, 1,0,0, ID,1,0,0,0, 0,0, 0,0);
        v(1,1,2,32'h24,32'h5A5A5A5A, 1,0,0, NS,1,0,0,0, 1,32'h20, 0,0);
        v(1,0,2,32'h98,0, 0,1,0, NS,0,0,0,0, 1,32'h24, 1,32'hA5A5A5A5);
        v(1,0,2,32'h98,0, 1,1,0, ID,0,0,0,0, 1,32'h24, 0,0);
        vi(0, NS,1,1,0, 1,32'h24, 0,0);
        vi(0, ID,0,0,0, 0,0, 1,32'h5A5A5A5A);
        vi(0, ID,1,0,0, 0,0, 0,0);
        vi(0, ID,0,0,0, 0,0, 0,0);
        // T5: misaligned halfword read 0x1 behind a word read 0x30
        v(1,0,2,32'h30,0, 1,0,0, ID,1,0,0,0, 0,0, 0,0);
        v(1,0,1,32'h1,0, 1,0,0, NS,1,0,0,0, 1,32'h30, 0,0);
        vi(32'h44444444, ID,0,0,0, 1,32'h1, 0,0);
        vi(32'hDEADDEAD, ID,1,0,32'h44444444, 0,0, 0,0);
        vi(0, ID,1,1,0, 0,0, 0,0);
        vi(0, ID,0,0,0, 0,0, 0,0);
        // T6: size==3 read, then byte read at odd address 0x43 (legal)
        v(1,0,3,32'h40,0, 1,0,0, ID,1,0,0,0, 0,0, 0,0);
        v(1,0,0,32'h43,0, 1,0,0, ID,1,0,0,0, 1,32'h40, 0,0);
        vi(32'hFFFFFFFF, NS,0,0,0, 1,32'h43, 0,0);
        vi(32'hAB000000, ID,1,1,0, 0,0, 0,0);
        vi(0, ID,1,0,32'hAB000000, 0,0, 0,0);
        vi(0, ID,0,0,0, 0,0, 0,0);

        // ------------------------------------------------ reset state
        HRESETn = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_size = 0; cmd_addr = 0; cmd_wdata = 0;
        HREADY = 1; HRESP = 2'b00; HRDATA = 0;
        #2;
        chk("rst HTRANS",    {30'h0, HTRANS}, 32'h0);
        chk("rst HADDR",     HADDR, 32'h0);
        chk("rst HWRITE",    {31'h0, HWRITE}, 32'h0);
        chk("rst HSIZE",     {29'h0, HSIZE}, 32'h0);
        chk("rst HWDATA",    HWDATA, 32'h0);
        chk("rst cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst rsp_rdata", rsp_rdata, 32'h0);
        chk("rst rsp_err",   {31'h0, rsp_err}, 32'h0);
        chk("HBURST",        {29'h0, HBURST}, 32'h0);
        chk("HPROT",         {28'h0, HPROT}, 32'h3);
        chk("HMASTLOCK",     {31'h0, HMASTLOCK}, 32'h0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // ------------------------------------------------ apply vectors
        foreach (vecs[i]) begin
            @(negedge HCLK);
            cmd_valid = vecs[i].cv; cmd_write = vecs[i].cw; cmd_size = vecs[i].cs;
            cmd_addr = vecs[i].ca;  cmd_wdata = vecs[i].cd;
            HREADY = vecs[i].hr; HRESP = {1'b0, vecs[i].he}; HRDATA = vecs[i].hrd;
            #1;
            chk($sformatf("v%0d HTRANS", i), {30'h0, HTRANS}, {30'h0, vecs[i].e_trans});
            chk($sformatf("v%0d cmd_ready", i), {31'h0, cmd_ready}, {31'h0, vecs[i].e_rdy});
            chk($sformatf("v%0d rsp_valid", i), {31'h0, rsp_valid}, {31'h0, vecs[i].e_rv});
            if (vecs[i].e_rv) begin
                chk($sformatf("v%0d rsp_err", i), {31'h0, rsp_err}, {31'h0, vecs[i].e_re});
                chk($sformatf("v%0d rsp_rdata", i), rsp_rdata, vecs[i].e_rd);
            end
            if (vecs[i].chk_a)
                chk($sformatf("v%0d HADDR", i), HADDR, vecs[i].e_haddr);
            if (vecs[i].chk_w)
                chk($sformatf("v%0d HWDATA", i), HWDATA, vecs[i].e_hwdata);
        end

        // ------------------------------------------------ reset during a wait state
        @(negedge HCLK);
        cmd_valid = 1; cmd_write = 1; cmd_size = 2; cmd_addr = 32'h200; cmd_wdata = 32'h12345678;
        HREADY = 1; HRESP = 2'b00;
        @(negedge HCLK);
        cmd_valid = 1; cmd_write = 0; cmd_size = 2; cmd_addr = 32'h204;
        @(negedge HCLK);
        cmd_valid = 0; HREADY = 0;
        #1;
        chk("wait HTRANS", {30'h0, HTRANS}, {30'h0, NS});
        chk("wait HWDATA", HWDATA, 32'h12345678);
        HRESETn = 1'b0;
        #1;
        chk("arst HTRANS",    {30'h0, HTRANS}, 32'h0);
        chk("arst rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("arst HADDR",     HADDR, 32'h0);
        chk("arst HWDATA",    HWDATA, 32'h0);
        chk("arst cmd_ready", {31'h0, cmd_ready}, 32'h1);
        HREADY = 1;
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            #1;
            chk($sformatf("post-rst%0d rsp_valid", k), {31'h0, rsp_valid}, 32'h0);
            chk($sformatf("post-rst%0d HTRANS", k), {30'h0, HTRANS}, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
